// File: rtl/rgb_to_hsv_pkg.sv
// Shared types and constants for the RGB-to-HSV converter.
// Optional feature macro: RGB2HSV_FLOAT_OUT_EN (adds the FLT state and float latency).
package hsv_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int HUE_K_DEF = 43;
    localparam int S_SCALE   = 255;

    localparam logic [7:0] BASE_R = 8'd0;
    localparam logic [7:0] BASE_G = 8'd85;
    localparam logic [7:0] BASE_B = 8'd171;

`ifdef RGB2HSV_FLOAT_OUT_EN
    localparam int LATENCY = 35;

    typedef enum logic [2:0] {
        IDLE, PREP, DIV_S, DIV_H, FLT, OUT
    } state_t;

    // value/256 as IEEE-754 single: exponent from the leading one, mantissa left-justified
    function automatic logic [31:0] u8ToFloat(input logic [7:0] x);
        logic [31:0] f;
        f = '0;
        for (int p = 0; p < 8; p++) begin
            if (x[p]) begin
                f[30:23] = 8'(119 + p);
                f[22:0]  = 23'(32'(x) << (23 - p));
            end
        end
        return f;
    endfunction
`else
    localparam int LATENCY = 34;

    typedef enum logic [2:0] {
        IDLE, PREP, DIV_S, DIV_H, OUT
    } state_t;
`endif

endpackage

// File: rtl/rgb_to_hsv_if.sv
// Pixel-in / HSV-out handshake bundle; float outputs exist only with RGB2HSV_FLOAT_OUT_EN.
interface rgb_to_hsv_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] h;
    logic [7:0] s;
    logic [7:0] v;
`ifdef RGB2HSV_FLOAT_OUT_EN
    logic [31:0] h_f;
    logic [31:0] s_f;
    logic [31:0] v_f;
`endif

    modport master (
        output in_valid, r, g, b, out_ready,
        input  in_ready, out_valid, h, s, v
`ifdef RGB2HSV_FLOAT_OUT_EN
        , input h_f, s_f, v_f
`endif
    );

    modport slave (
        input  in_valid, r, g, b, out_ready,
        output in_ready, out_valid, h, s, v
`ifdef RGB2HSV_FLOAT_OUT_EN
        , output h_f, s_f, v_f
`endif
    );

endinterface

// File: rtl/rgb_to_hsv_divider.sv
// Restoring divider, one quotient bit per cycle; the start cycle already resolves the first bit.
module seq_divider #(
    parameter int W     = 16,
    parameter int DVS_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     quotient
);

    localparam int CW = $clog2(W) + 1;

    logic [DVS_W-1:0] r_rem;
    logic [W-1:0]     r_dq;
    logic [DVS_W-1:0] r_dvs;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;

    logic [DVS_W-1:0] w_remSrc;
    logic [W-1:0]     w_dqSrc;
    logic [DVS_W-1:0] w_dvsSrc;
    logic [DVS_W:0]   w_trial;
    logic             w_ge;
    logic [DVS_W-1:0] w_remNext;
    logic [W-1:0]     w_dqNext;

    // A zero divisor makes every trial succeed, so the quotient saturates to all-ones
    always_comb begin
        w_remSrc  = start ? '0 : r_rem;
        w_dqSrc   = start ? dividend : r_dq;
        w_dvsSrc  = start ? divisor : r_dvs;
        w_trial   = {w_remSrc, w_dqSrc[W-1]};
        w_ge      = (w_trial >= {1'b0, w_dvsSrc});
        w_remNext = w_ge ? DVS_W'(w_trial - {1'b0, w_dvsSrc}) : w_trial[DVS_W-1:0];
        w_dqNext  = {w_dqSrc[W-2:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem   <= '0;
            r_dq    <= '0;
            r_dvs   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem   <= w_remNext;
                r_dq    <= w_dqNext;
                r_dvs   <= divisor;
                r_count <= CW'(1);
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                r_rem   <= w_remNext;
                r_dq    <= w_dqNext;
                r_count <= r_count + CW'(1);
                if (r_count == CW'(W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign quotient = r_dq;

endmodule

// File: rtl/rgb_to_hsv.sv
// Iterative RGB-to-HSV converter sharing one divider for saturation and hue.
// Optional feature macro: RGB2HSV_FLOAT_OUT_EN (float h_f/s_f/v_f outputs, one extra cycle).
module rgb_to_hsv
    import hsv_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int HUE_K = HUE_K_DEF
) (
    input  logic         clk,
    input  logic         reset,
    rgb_to_hsv_if.slave  bus
);

    state_t     r_state;
    logic       r_inReady;
    logic       r_outValid;
    logic [7:0] r_h;
    logic [7:0] r_s;
    logic [7:0] r_v;
    logic [7:0] r_rIn;
    logic [7:0] r_gIn;
    logic [7:0] r_bIn;
    logic [7:0] r_max;
    logic [7:0] r_delta;
    logic [7:0] r_base;
    logic [7:0] r_absDiff;
    logic       r_diffNeg;
    logic [7:0] r_sCalc;
    logic       r_divStart;
`ifdef RGB2HSV_FLOAT_OUT_EN
    logic [7:0]  r_hCalc;
    logic [31:0] r_hF;
    logic [31:0] r_sF;
    logic [31:0] r_vF;
`endif

    logic [7:0]       w_max;
    logic [7:0]       w_min;
    logic [7:0]       w_base;
    logic [7:0]       w_diffA;
    logic [7:0]       w_diffB;
    logic             w_diffNeg;
    logic [7:0]       w_absDiff;
    logic             w_divStart;
    logic [DIV_W-1:0] w_divDividend;
    logic [7:0]       w_divDivisor;
    logic             w_divBusy;
    logic             w_divDone;
    logic [DIV_W-1:0] w_divQuot;
    logic [7:0]       w_q8;
    logic [7:0]       w_hCalc;

    // Max tie priority is r, then g, then b; the sector diff follows the winning channel
    always_comb begin
        w_max   = r_bIn;
        w_base  = BASE_B;
        w_diffA = r_rIn;
        w_diffB = r_gIn;
        if (r_rIn >= r_gIn && r_rIn >= r_bIn) begin
            w_max   = r_rIn;
            w_base  = BASE_R;
            w_diffA = r_gIn;
            w_diffB = r_bIn;
        end else if (r_gIn >= r_bIn) begin
            w_max   = r_gIn;
            w_base  = BASE_G;
            w_diffA = r_bIn;
            w_diffB = r_rIn;
        end
        w_min = r_rIn;
        if (r_gIn < w_min) w_min = r_gIn;
        if (r_bIn < w_min) w_min = r_bIn;
        w_diffNeg = (w_diffA < w_diffB);
        w_absDiff = w_diffNeg ? (w_diffB - w_diffA) : (w_diffA - w_diffB);
    end

    // Second divide launches on the same edge the saturation quotient is taken
    assign w_divStart    = !w_divBusy && (r_divStart || (r_state == DIV_S && w_divDone));
    assign w_divDividend = r_divStart ? DIV_W'(S_SCALE * 32'(r_delta))
                                      : DIV_W'(HUE_K * 32'(r_absDiff));
    assign w_divDivisor  = r_divStart ? r_max : r_delta;

    seq_divider #(.W(DIV_W), .DVS_W(8)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (w_divStart),
        .dividend (w_divDividend),
        .divisor  (w_divDivisor),
        .busy     (w_divBusy),
        .done     (w_divDone),
        .quotient (w_divQuot)
    );

    assign w_q8    = (|w_divQuot[DIV_W-1:8]) ? 8'hFF : w_divQuot[7:0];
    assign w_hCalc = (r_delta == 8'd0) ? 8'd0
                   : (r_diffNeg ? (r_base - w_q8) : (r_base + w_q8));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_h        <= '0;
            r_s        <= '0;
            r_v        <= '0;
            r_rIn      <= '0;
            r_gIn      <= '0;
            r_bIn      <= '0;
            r_max      <= '0;
            r_delta    <= '0;
            r_base     <= '0;
            r_absDiff  <= '0;
            r_diffNeg  <= 1'b0;
            r_sCalc    <= '0;
            r_divStart <= 1'b0;
`ifdef RGB2HSV_FLOAT_OUT_EN
            r_hCalc    <= '0;
            r_hF       <= '0;
            r_sF       <= '0;
            r_vF       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_rIn     <= bus.r;
                        r_gIn     <= bus.g;
                        r_bIn     <= bus.b;
                        r_inReady <= 1'b0;
                        r_state   <= PREP;
                    end
                end
                PREP: begin
                    r_max      <= w_max;
                    r_delta    <= w_max - w_min;
                    r_base     <= w_base;
                    r_absDiff  <= w_absDiff;
                    r_diffNeg  <= w_diffNeg;
                    r_divStart <= 1'b1;
                    r_state    <= DIV_S;
                end
                DIV_S: begin
                    r_divStart <= 1'b0;
                    if (w_divDone) begin
                        r_sCalc <= (r_max == 8'd0 || r_delta == 8'd0) ? 8'd0 : w_q8;
                        r_state <= DIV_H;
                    end
                end
                DIV_H: begin
                    if (w_divDone) begin
`ifdef RGB2HSV_FLOAT_OUT_EN
                        r_hCalc <= w_hCalc;
                        r_state <= FLT;
`else
                        r_h        <= w_hCalc;
                        r_s        <= r_sCalc;
                        r_v        <= r_max;
                        r_outValid <= 1'b1;
                        r_state    <= OUT;
`endif
                    end
                end
`ifdef RGB2HSV_FLOAT_OUT_EN
                FLT: begin
                    r_h        <= r_hCalc;
                    r_s        <= r_sCalc;
                    r_v        <= r_max;
                    r_hF       <= u8ToFloat(r_hCalc);
                    r_sF       <= u8ToFloat(r_sCalc);
                    r_vF       <= u8ToFloat(r_max);
                    r_outValid <= 1'b1;
                    r_state    <= OUT;
                end
`endif
                OUT: begin
                    if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.h         = r_h;
    assign bus.s         = r_s;
    assign bus.v         = r_v;
`ifdef RGB2HSV_FLOAT_OUT_EN
    assign bus.h_f = r_hF;
    assign bus.s_f = r_sF;
    assign bus.v_f = r_vF;
`endif

endmodule
